// File: rtl/mux_scan_pkg.sv
// Shared types and helpers for the mux_scan block.
// State encoding and select-width sizing.
package mux_scan_pkg;

  typedef enum logic {
    ST_MANUAL = 1'b0,
    ST_SCAN   = 1'b1
  } state_t;

  function automatic int clog2_min1(input int n);
    int r;
    r = $clog2(n);
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/mux_scan_scan_counter.sv
// Scan channel/dwell counters with hold, clear and wrap pulse.
// wrap lands on the step that first presents channel 0 again.
module scan_counter
  import mux_scan_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int DWELL    = 4,
  localparam int CH_W    = clog2_min1(CHANNELS),
  localparam int DC_W    = clog2_min1(DWELL)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            hold,
  input  logic            clear,
  output logic [CH_W-1:0] ch,
  output logic [DC_W-1:0] dcnt,
  output logic            wrap
);

  logic last_d;
  logic last_ch;
  logic pend;

  assign last_d  = (dcnt == DC_W'(DWELL - 1));
  assign last_ch = (ch == CH_W'(CHANNELS - 1));

  // Advance dwell/channel; pend remembers a wrap for the next step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch   <= '0;
      dcnt <= '0;
      pend <= 1'b0;
      wrap <= 1'b0;
    end else if (hold) begin
      wrap <= 1'b0;
    end else if (clear) begin
      ch   <= '0;
      dcnt <= '0;
      pend <= 1'b0;
      wrap <= 1'b0;
    end else begin
      wrap <= pend;
      pend <= last_d && last_ch;
      if (last_d) begin
        dcnt <= '0;
        ch   <= last_ch ? '0 : ch + CH_W'(1);
      end else begin
        dcnt <= dcnt + DC_W'(1);
      end
    end
  end

endmodule

// File: rtl/mux_scan.sv
// Registered N-channel word mux with manual and auto-scan modes.
// Output inversion, hold freeze, range error flag.
module mux_scan
  import mux_scan_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int DWELL    = 4,
  localparam int SEL_W   = clog2_min1(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel_in,
  input  logic                      hold,
  input  logic                      invert,
  input  logic [CHANNELS*WIDTH-1:0] data_in,
  output logic [WIDTH-1:0]          y,
  output logic [SEL_W-1:0]          sel_out,
  output logic                      valid,
  output logic                      wrap,
  output logic                      err
);

  localparam logic [SEL_W:0] CH_LIM = (SEL_W + 1)'(CHANNELS);
  localparam int DC_W = clog2_min1(DWELL);

  state_t             state_q;
  state_t             state_d;
  logic [SEL_W-1:0]   ch;
  logic [DC_W-1:0]    dcnt;
  logic               in_range;
  logic [WIDTH-1:0]   y_d;
  logic [SEL_W-1:0]   sel_d;
  logic               valid_d;
  logic               err_d;
  logic               clear;

  assign in_range = ({1'b0, sel_in} < CH_LIM);
  assign clear    = (state_d == ST_MANUAL);

  scan_counter #(
    .CHANNELS (CHANNELS),
    .DWELL    (DWELL)
  ) u_scan (
    .clk   (clk),
    .rst_n (rst_n),
    .hold  (hold),
    .clear (clear),
    .ch    (ch),
    .dcnt  (dcnt),
    .wrap  (wrap)
  );

  // Next mode and next output word; hold freezes everything
  always_comb begin
    state_d = state_q;
    y_d     = y;
    sel_d   = sel_out;
    valid_d = valid;
    err_d   = err;
    if (!hold) begin
      state_d = mode ? ST_SCAN : ST_MANUAL;
      unique case (1'b1)
        state_d == ST_SCAN: begin
          y_d     = data_in[ch*WIDTH +: WIDTH] ^ {WIDTH{invert}};
          sel_d   = ch;
          valid_d = 1'b1;
          err_d   = 1'b0;
        end
        state_d == ST_MANUAL && in_range: begin
          y_d     = data_in[sel_in*WIDTH +: WIDTH] ^ {WIDTH{invert}};
          sel_d   = sel_in;
          valid_d = 1'b1;
          err_d   = 1'b0;
        end
        default: begin
          y_d     = '0;
          valid_d = 1'b0;
          err_d   = 1'b1;
        end
      endcase
    end
  end

  // Mode and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_MANUAL;
      y       <= '0;
      sel_out <= '0;
      valid   <= 1'b0;
      err     <= 1'b0;
    end else begin
      state_q <= state_d;
      y       <= y_d;
      sel_out <= sel_d;
      valid   <= valid_d;
      err     <= err_d;
    end
  end

  logic unused_dcnt;
  assign unused_dcnt = ^dcnt;

endmodule

// File: tb/tb_mux_scan.sv
// Self-checking bench for mux_scan: two instances (4x2, 3x1).
// Reference model tracks scan position as a flat cycle index.
module tb_mux_scan;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mode;
  logic        hold;
  logic        invert;
  logic [1:0]  sel_in;
  logic [31:0] data_a;
  logic [23:0] data_b;

  logic [7:0] ya, yb;
  logic [1:0] sa, sb;
  logic       va, vb, wa, wb, ea, eb;

  int n_chk  = 0;
  int n_fail = 0;

  int         mc [2] = '{4, 3};
  int         md [2] = '{2, 1};
  int         pos [2];
  int         steps [2];
  logic [7:0] ey [2];
  logic [1:0] es [2];
  logic       ev [2];
  logic       ew [2];
  logic       ee [2];

  logic [7:0] seq [9] = '{8'h10, 8'h10, 8'h20, 8'h20, 8'h30,
                          8'h30, 8'h40, 8'h40, 8'h10};

  always #5 clk = ~clk;

  assign data_b = data_a[23:0];

  mux_scan #(.WIDTH(8), .CHANNELS(4), .DWELL(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel_in(sel_in),
    .hold(hold), .invert(invert), .data_in(data_a),
    .y(ya), .sel_out(sa), .valid(va), .wrap(wa), .err(ea)
  );

  mux_scan #(.WIDTH(8), .CHANNELS(3), .DWELL(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel_in(sel_in),
    .hold(hold), .invert(invert), .data_in(data_b),
    .y(yb), .sel_out(sb), .valid(vb), .wrap(wb), .err(eb)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] word(input int c);
    return data_a[c*8 +: 8];
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      pos[k] = 0; steps[k] = 0;
      ey[k] = '0; es[k] = '0;
      ev[k] = 0; ew[k] = 0; ee[k] = 0;
    end
  endtask

  task automatic model_edge();
    int c;
    for (int k = 0; k < 2; k++) begin
      if (hold) begin
        ew[k] = 0;
      end else if (mode) begin
        c = pos[k] / md[k];
        ey[k] = word(c) ^ {8{invert}};
        es[k] = 2'(c);
        ev[k] = 1; ee[k] = 0;
        ew[k] = (pos[k] == 0) && (steps[k] > 0);
        steps[k]++;
        pos[k] = (pos[k] + 1) % (mc[k] * md[k]);
      end else begin
        pos[k] = 0; steps[k] = 0; ew[k] = 0;
        if (int'(sel_in) < mc[k]) begin
          ey[k] = word(int'(sel_in)) ^ {8{invert}};
          es[k] = sel_in;
          ev[k] = 1; ee[k] = 0;
        end else begin
          ey[k] = '0; ev[k] = 0; ee[k] = 1;
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".a.y"}, ya, ey[0]);
    chk({tag, ".a.sel"}, sa, es[0]);
    chk({tag, ".a.valid"}, va, ev[0]);
    chk({tag, ".a.wrap"}, wa, ew[0]);
    chk({tag, ".a.err"}, ea, ee[0]);
    chk({tag, ".b.y"}, yb, ey[1]);
    chk({tag, ".b.sel"}, sb, es[1]);
    chk({tag, ".b.valid"}, vb, ev[1]);
    chk({tag, ".b.wrap"}, wb, ew[1]);
    chk({tag, ".b.err"}, eb, ee[1]);
  endtask

  task automatic cyc(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  initial begin
    rst_n = 0; mode = 0; hold = 0; invert = 0; sel_in = 0;
    data_a = $urandom;
    #12;
    model_reset();
    check_all("reset");
    rst_n = 1;

    sel_in = 2; data_a[23:16] = 8'hA5;
    cyc("man_a5");
    chk("man_a5.y", ya, 8'hA5);

    sel_in = 1; data_a[15:8] = 8'h3C; invert = 1;
    cyc("man_inv");
    chk("man_inv.y", ya, 8'hC3);
    chk("man_inv.sel", sa, 1);

    invert = 0; sel_in = 3;
    cyc("man_oor");
    chk("man_oor.err", eb, 1);
    chk("man_oor.y", yb, 0);
    chk("man_oor.valid", vb, 0);

    data_a = 32'h40302010; mode = 1;
    for (int i = 0; i < 9; i++) begin
      cyc("scan");
      chk("scan.seq", ya, seq[i]);
      chk("scan.wrap", wa, (i == 8));
      if (i == 4) begin
        hold = 1;
        for (int h = 0; h < 5; h++) begin
          cyc("hold");
          chk("hold.y", ya, 8'h30);
          chk("hold.sel", sa, 2);
        end
        hold = 0;
      end
    end

    repeat (6) cyc("to_ch3");
    chk("to_ch3.sel", sa, 3);
    mode = 0; sel_in = 0;
    cyc("sw_man");
    chk("sw_man.y", ya, 8'h10);
    mode = 1;
    cyc("sw_scan0");
    chk("sw_scan0.y", ya, 8'h10);
    chk("sw_scan0.sel", sa, 0);
    cyc("sw_scan1");
    cyc("sw_scan2");
    chk("sw_scan2.y", ya, 8'h20);

    repeat (3) cyc("pre_arst");
    #2 rst_n = 0;
    #1 model_reset();
    check_all("arst");
    rst_n = 1;
    for (int i = 1; i <= 9; i++) begin
      cyc("restart");
      chk("restart.wrap", wa, (i == 9));
    end

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) mode = ~mode;
      hold   = ($urandom_range(0, 5) == 0);
      invert = 1'($urandom);
      sel_in = 2'($urandom);
      data_a = $urandom;
      if ($urandom_range(0, 99) == 0) begin
        #2 rst_n = 0;
        #1 model_reset();
        check_all("rnd_arst");
        rst_n = 1;
      end
      cyc("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
